instr_fetch_queue: RTL and testbench

//   Fetch stage upstream of the single-cycle datapath. Owns the fetch PC, issues

---
 rtl/instr_fetch_queue_if.sv | 23 ++
 rtl/instr_fetch_queue.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory read port, redirect request and the
// valid/ready handshake towards decode. "master" is the fetch queue side.
interface instr_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    input  imem_data, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    output imem_data, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues 1-cycle-latency reads to instruction memory,
// buffers {instr, pc} in a DEPTH-entry FIFO and hands them to decode. Handles redirect
// with flush and stops fetching after a HALT_OP word is enqueued.
// Optional build macro FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module instr_fetch_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [31:0] PC_INC  = 32'd1,
  parameter logic [4:0]  HALT_OP = 5'h1F
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [31:0]            startPC,
  instr_fetch_queue_if.master    bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]            stat_fetched,
  output logic [31:0]            stat_flushed
`endif
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  typedef enum logic [0:0] {StFetch, StHalted} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     inflight_pc_q;
  logic [31:0]     fifo_instr_q [DEPTH];
  logic [31:0]     fifo_pc_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0] count_q, count_d;
  logic [31:0]     held_instr_q, held_pc_q;
  logic            credit_ok, halt_word, push, pop, issue;

  // Handshake decode: returns are dropped on redirect or once halted; no issue while a
  // HALT word is landing so nothing is fetched past it.
  always_comb begin
    credit_ok = (32'(count_q) + 32'(inflight_q)) < DEPTH;
    halt_word = bus.imem_data[31:27] == HALT_OP;
    push      = inflight_q && !bus.redirect && (state_q == StFetch);
    pop       = (count_q != '0) && bus.instr_ready && !bus.redirect;
    issue     = !RESET && !bus.redirect && (state_q == StFetch) && credit_ok &&
                !(push && halt_word);
  end

  // Fetch FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (push && halt_word) state_d = StHalted;
      StHalted: if (bus.redirect) state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // PC, pointer and occupancy next state; redirect flushes everything.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = issue;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + PC_INC;
      if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + OccW'(push) - OccW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= StFetch;
      fetch_pc_q    <= startPC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      held_instr_q  <= '0;
      held_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      held_instr_q <= bus.instr_out;
      held_pc_q    <= bus.instr_pc;
      if (issue) inflight_pc_q <= fetch_pc_q;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge CLK) begin
    if (!RESET && push) begin
      fifo_instr_q[wr_ptr_q] <= bus.imem_data;
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  // Outputs; head fields fall back to the last shown value when empty.
  always_comb begin
    bus.imem_req    = issue;
    bus.imem_addr   = fetch_pc_q;
    bus.instr_valid = count_q != '0;
    bus.instr_out   = bus.instr_valid ? fifo_instr_q[rd_ptr_q] : held_instr_q;
    bus.instr_pc    = bus.instr_valid ? fifo_pc_q[rd_ptr_q] : held_pc_q;
    occupancy       = count_q;
    halted          = state_q == StHalted;
  end

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_flushed_q;
  logic [32:0] flush_sum;

  // Discarded work on redirect = queued entries plus the squashed in-flight response.
  always_comb begin
    flush_sum = 33'(stat_flushed_q) + 33'(count_q) + 33'(inflight_q);
  end

  // Saturating statistics counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      if (push && (stat_fetched_q != '1)) stat_fetched_q <= stat_fetched_q + 32'd1;
      if (bus.redirect) stat_flushed_q <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: table of per-cycle vectors for streaming, backpressure
// and redirect, then hand sequences for halt, PC wrap and (optionally) statistics.
module tb_instr_fetch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] start_pc;
  logic [2:0]  occupancy;
  logic        halted;
  logic        halt_en = 1'b0;
  int          nvec = 0;
  int          nerr = 0;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushed;
`endif

  instr_fetch_queue_if bus ();

  instr_fetch_queue #(
    .DEPTH(4),
    .PC_INC(32'd1),
    .HALT_OP(5'h1F)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .startPC(start_pc),
    .bus(bus),
    .occupancy(occupancy),
    .halted(halted)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_flushed(stat_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Memory word for address a; tagged so instr and pc differ.
  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic hen);
    if (hen && a == 32'h12) return 32'hF800_0012;
    return tag(a);
  endfunction

  // One-cycle read latency memory model.
  always @(posedge clk) if (bus.imem_req) bus.imem_data <= mem_word(bus.imem_addr, halt_en);

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  occ;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic rdy, input logic rd, input logic [31:0] rpc,
                              input logic req, input logic [31:0] addr, input logic vld,
                              input logic [31:0] pc, input logic [2:0] occ);
    vec_t v;
    v.ready = rdy; v.redir = rd; v.rpc = rpc; v.req = req;
    v.addr = addr; v.valid = vld; v.pc = pc; v.occ = occ;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic rd, input logic [31:0] rpc);
    bus.instr_ready = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
  endtask

  // Applies one reset edge, checks reset outputs, releases reset at the next edge.
  task automatic do_reset(input logic [31:0] spc);
    drive(1'b1, 1'b0, 32'h0);
    start_pc = spc;
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst valid", 32'(bus.instr_valid), 32'd0);
    chk("rst instr_out", bus.instr_out, 32'd0);
    chk("rst instr_pc", bus.instr_pc, 32'd0);
    chk("rst occupancy", 32'(occupancy), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Stream from 0x10, stall 10 cycles, resume, then redirect to 0x40 with 3+1 held.
    vecs[0]  = mk(1, 0, 0,     1, 32'h10, 0, 0,      0);
    vecs[1]  = mk(1, 0, 0,     1, 32'h11, 0, 0,      0);
    vecs[2]  = mk(1, 0, 0,     1, 32'h12, 1, 32'h10, 1);
    vecs[3]  = mk(1, 0, 0,     1, 32'h13, 1, 32'h11, 1);
    vecs[4]  = mk(0, 0, 0,     1, 32'h14, 1, 32'h12, 1);
    vecs[5]  = mk(0, 0, 0,     1, 32'h15, 1, 32'h12, 2);
    vecs[6]  = mk(0, 0, 0,     0, 0,      1, 32'h12, 3);
    for (int i = 7; i <= 13; i++) vecs[i] = mk(0, 0, 0, 0, 0, 1, 32'h12, 4);
    vecs[14] = mk(1, 0, 0,     0, 0,      1, 32'h12, 4);
    vecs[15] = mk(1, 0, 0,     1, 32'h16, 1, 32'h13, 3);
    vecs[16] = mk(1, 0, 0,     1, 32'h17, 1, 32'h14, 2);
    vecs[17] = mk(1, 0, 0,     1, 32'h18, 1, 32'h15, 2);
    vecs[18] = mk(0, 0, 0,     1, 32'h19, 1, 32'h16, 2);
    vecs[19] = mk(0, 1, 32'h40, 0, 0,     1, 32'h16, 3);
    vecs[20] = mk(1, 0, 0,     1, 32'h40, 0, 0,      0);
    vecs[21] = mk(1, 0, 0,     1, 32'h41, 0, 0,      0);
    vecs[22] = mk(1, 0, 0,     1, 32'h42, 1, 32'h40, 1);
    vecs[23] = mk(1, 0, 0,     1, 32'h43, 1, 32'h41, 1);

    do_reset(32'h10);
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      @(negedge clk);
      chk($sformatf("v%0d imem_req", i), 32'(bus.imem_req), 32'(vecs[i].req));
      if (vecs[i].req) chk($sformatf("v%0d imem_addr", i), bus.imem_addr, vecs[i].addr);
      chk($sformatf("v%0d valid", i), 32'(bus.instr_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        chk($sformatf("v%0d instr_pc", i), bus.instr_pc, vecs[i].pc);
        chk($sformatf("v%0d instr_out", i), bus.instr_out, tag(vecs[i].pc));
      end
      chk($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(vecs[i].occ));
      tick();
    end

    // HALT word at 0x12: delivered, fetch stops, redirect to 0 resumes.
    halt_en = 1'b1;
    do_reset(32'h10);
    drive(1'b1, 1'b0, 32'h0);
    repeat (3) tick();
    @(negedge clk);
    chk("halt c3 imem_req", 32'(bus.imem_req), 32'd0);
    chk("halt c3 instr_pc", bus.instr_pc, 32'h11);
    tick();
    @(negedge clk);
    chk("halt c4 halted", 32'(halted), 32'd1);
    chk("halt c4 imem_req", 32'(bus.imem_req), 32'd0);
    chk("halt c4 instr_pc", bus.instr_pc, 32'h12);
    chk("halt c4 instr_out", bus.instr_out, 32'hF800_0012);
    chk("halt c4 occupancy", 32'(occupancy), 32'd1);
    tick();
    @(negedge clk);
    chk("halt c5 valid", 32'(bus.instr_valid), 32'd0);
    chk("halt c5 imem_req", 32'(bus.imem_req), 32'd0);
    chk("halt c5 halted", 32'(halted), 32'd1);
    tick();
    drive(1'b1, 1'b1, 32'h0);
    @(negedge clk);
    chk("halt redirect-cycle halted", 32'(halted), 32'd1);
    tick();
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("resume halted", 32'(halted), 32'd0);
    chk("resume imem_req", 32'(bus.imem_req), 32'd1);
    chk("resume imem_addr", bus.imem_addr, 32'h0);
    repeat (2) tick();
    @(negedge clk);
    chk("resume valid", 32'(bus.instr_valid), 32'd1);
    chk("resume instr_pc", bus.instr_pc, 32'h0);
    halt_en = 1'b0;

    // PC wrap from 0xFFFFFFFF; reset lands mid-stream so stale returns must vanish.
    do_reset(32'hFFFF_FFFF);
    @(negedge clk);
    chk("wrap addr0", bus.imem_addr, 32'hFFFF_FFFF);
    tick();
    @(negedge clk);
    chk("wrap addr1", bus.imem_addr, 32'h0);
    tick();
    @(negedge clk);
    chk("wrap head pc0", bus.instr_pc, 32'hFFFF_FFFF);
    chk("wrap head instr0", bus.instr_out, tag(32'hFFFF_FFFF));
    tick();
    @(negedge clk);
    chk("wrap head pc1", bus.instr_pc, 32'h0);
    chk("wrap head instr1", bus.instr_out, tag(32'h0));

`ifdef FETCH_STATS_EN
    // Six pushes, then redirect with three queued and one in flight.
    do_reset(32'h10);
    drive(1'b1, 1'b0, 32'h0);
    repeat (5) tick();
    drive(1'b0, 1'b0, 32'h0);
    repeat (2) tick();
    drive(1'b0, 1'b1, 32'h40);
    @(negedge clk);
    chk("stats occupancy pre-flush", 32'(occupancy), 32'd3);
    chk("stats fetched pre-flush", stat_fetched, 32'd6);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("stats fetched", stat_fetched, 32'd6);
    chk("stats flushed", stat_flushed, 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
